// File: rtl/issue_classify_queue_pkg.sv
// Shared instruction type codes and class codes for the issue classify queue.
package issue_classify_queue_pkg;

    localparam int INST_TYPE_WIDTH = 6;
    localparam int CLASS_W         = 3;

    localparam int unsigned INST_LUI   = 1;
    localparam int unsigned INST_AUIPC = 2;
    localparam int unsigned INST_JAL   = 3;
    localparam int unsigned INST_JALR  = 4;
    localparam int unsigned INST_BEQ   = 5;
    localparam int unsigned INST_BNE   = 6;
    localparam int unsigned INST_BLT   = 7;
    localparam int unsigned INST_BGE   = 8;
    localparam int unsigned INST_BLTU  = 9;
    localparam int unsigned INST_BGEU  = 10;
    localparam int unsigned INST_LB    = 11;
    localparam int unsigned INST_LH    = 12;
    localparam int unsigned INST_LW    = 13;
    localparam int unsigned INST_LBU   = 14;
    localparam int unsigned INST_LHU   = 15;
    localparam int unsigned INST_SB    = 16;
    localparam int unsigned INST_SH    = 17;
    localparam int unsigned INST_SW    = 18;
    localparam int unsigned INST_ADDI  = 19;
    localparam int unsigned INST_SLTI  = 20;
    localparam int unsigned INST_SLTIU = 21;
    localparam int unsigned INST_XORI  = 22;
    localparam int unsigned INST_ORI   = 23;
    localparam int unsigned INST_ANDI  = 24;
    localparam int unsigned INST_SLLI  = 25;
    localparam int unsigned INST_SRLI  = 26;
    localparam int unsigned INST_SRAI  = 27;
    localparam int unsigned INST_ADD   = 28;
    localparam int unsigned INST_SUB   = 29;
    localparam int unsigned INST_SLL   = 30;
    localparam int unsigned INST_SLT   = 31;
    localparam int unsigned INST_SLTU  = 32;
    localparam int unsigned INST_XOR   = 33;
    localparam int unsigned INST_SRL   = 34;
    localparam int unsigned INST_SRA   = 35;
    localparam int unsigned INST_OR    = 36;
    localparam int unsigned INST_AND   = 37;

    typedef enum logic [CLASS_W-1:0] {
        CLS_CALC    = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd7
    } inst_class_e;

endpackage

// File: rtl/issue_classify_queue_decode.sv
// Purely combinational instruction type -> class code decoder.
module inst_class_decode
    import issue_classify_queue_pkg::*;
#(
    parameter int TYPE_W = INST_TYPE_WIDTH
) (
    input  logic [TYPE_W-1:0] type_i,
    output inst_class_e       class_o
);

    // NOTE: every path assigns class_o via the default, so no latch is inferred.
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (32'(type_i))
            INST_LUI, INST_AUIPC, INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
            INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND, INST_ADDI, INST_SLTI,
            INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI, INST_SLLI, INST_SRLI,
            INST_SRAI:                                          class_o = CLS_CALC;
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU:      class_o = CLS_LOAD;
            INST_SB, INST_SH, INST_SW:                          class_o = CLS_STORE;
            INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU,
            INST_BGEU:                                          class_o = CLS_BRANCH;
            INST_JAL, INST_JALR:                                class_o = CLS_JUMP;
            default:                                            class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/issue_classify_queue.sv
// In-order classify-and-dispatch queue between decoder and issue (RS / LSB).
// Optional per-class counters enabled by defining ISSUE_CLASSIFY_PERF_EN.
module issue_classify_queue
    import issue_classify_queue_pkg::*;
#(
    parameter int TYPE_W = INST_TYPE_WIDTH,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
`ifdef ISSUE_CLASSIFY_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TYPE_W-1:0]  in_type,
    input  logic [31:0]        in_pc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               rs_valid,
    input  logic               rs_ready,
    output logic               lsb_valid,
    input  logic               lsb_ready,
    output logic [TYPE_W-1:0]  out_type,
    output logic [CLASS_W-1:0] out_class,
    output logic [31:0]        out_pc,
    output logic [TAG_W-1:0]   out_tag,
    output logic               illegal
`ifdef ISSUE_CLASSIFY_PERF_EN
    , output logic [CNT_W-1:0] perf_calc
    , output logic [CNT_W-1:0] perf_mem
    , output logic [CNT_W-1:0] perf_ctrl
    , output logic [CNT_W-1:0] perf_illegal
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [TYPE_W-1:0] type_q  [DEPTH];
    inst_class_e       class_q [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];

    inst_class_e enq_class;
    inst_class_e head_class;
    logic        not_empty, head_illegal, push, pop;

    inst_class_decode #(.TYPE_W(TYPE_W)) u_decode (
        .type_i  (in_type),
        .class_o (enq_class)
    );

    assign not_empty    = (count_q != '0);
    assign head_class   = class_q[rd_ptr_q];
    assign head_illegal = not_empty && (head_class == CLS_ILLEGAL);
    assign in_ready     = (count_q != FULL_CNT);
    assign push         = in_valid && in_ready;
    assign pop          = (rs_valid && rs_ready) || (lsb_valid && lsb_ready) || head_illegal;

    always_comb begin
        rs_valid  = not_empty && (head_class inside {CLS_CALC, CLS_BRANCH, CLS_JUMP});
        lsb_valid = not_empty && (head_class inside {CLS_LOAD, CLS_STORE});
        illegal   = head_illegal && !flush && !rst;
        out_type  = '0;
        out_class = '0;
        out_pc    = '0;
        out_tag   = '0;
        if (not_empty) begin
            out_type  = type_q[rd_ptr_q];
            out_class = head_class;
            out_pc    = pc_q[rd_ptr_q];
            out_tag   = tag_q[rd_ptr_q];
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // NOTE: payload storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            type_q[wr_ptr_q]  <= in_type;
            class_q[wr_ptr_q] <= enq_class;
            pc_q[wr_ptr_q]    <= in_pc;
            tag_q[wr_ptr_q]   <= in_tag;
        end
    end

`ifdef ISSUE_CLASSIFY_PERF_EN
    logic [CNT_W-1:0] perf_calc_q, perf_calc_d, perf_mem_q, perf_mem_d;
    logic [CNT_W-1:0] perf_ctrl_q, perf_ctrl_d, perf_illegal_q, perf_illegal_d;
    logic             retire;

    // A pop cancelled by flush never happened, so it is not counted.
    assign retire = pop && !flush;

    always_comb begin
        perf_calc_d    = perf_calc_q;
        perf_mem_d     = perf_mem_q;
        perf_ctrl_d    = perf_ctrl_q;
        perf_illegal_d = perf_illegal_q;
        if (retire) begin
            case (head_class)
                CLS_CALC:             if (perf_calc_q != '1)    perf_calc_d    = perf_calc_q + 1'b1;
                CLS_LOAD, CLS_STORE:  if (perf_mem_q != '1)     perf_mem_d     = perf_mem_q + 1'b1;
                CLS_BRANCH, CLS_JUMP: if (perf_ctrl_q != '1)    perf_ctrl_d    = perf_ctrl_q + 1'b1;
                default:              if (perf_illegal_q != '1) perf_illegal_d = perf_illegal_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_calc_q    <= '0;
            perf_mem_q     <= '0;
            perf_ctrl_q    <= '0;
            perf_illegal_q <= '0;
        end else begin
            perf_calc_q    <= perf_calc_d;
            perf_mem_q     <= perf_mem_d;
            perf_ctrl_q    <= perf_ctrl_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_calc    = perf_calc_q;
    assign perf_mem     = perf_mem_q;
    assign perf_ctrl    = perf_ctrl_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_issue_classify_queue.sv
// Self-checking bench for issue_classify_queue: scripted scenarios plus random traffic vs a queue model.
module tb_issue_classify_queue;
    import issue_classify_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int VW    = 49;

    localparam logic [5:0] T_ADD  = 6'(INST_ADD);
    localparam logic [5:0] T_ADDI = 6'(INST_ADDI);
    localparam logic [5:0] T_LW   = 6'(INST_LW);
    localparam logic [5:0] T_SW   = 6'(INST_SW);
    localparam logic [5:0] T_BEQ  = 6'(INST_BEQ);
    localparam logic [5:0] T_BAD  = 6'd50;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, rs_ready = 1'b0, lsb_ready = 1'b0;
    logic [5:0]  in_type = '0;
    logic [31:0] in_pc = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, rs_valid, lsb_valid, illegal;
    logic [5:0]  out_type;
    logic [2:0]  out_class;
    logic [31:0] out_pc;
    logic [3:0]  out_tag;
`ifdef ISSUE_CLASSIFY_PERF_EN
    logic [1:0]  perf_calc, perf_mem, perf_ctrl, perf_illegal;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  ty;
        logic [31:0] pc;
        logic [3:0]  tag;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    issue_classify_queue #(
        .TYPE_W(6), .TAG_W(4), .DEPTH(DEPTH)
`ifdef ISSUE_CLASSIFY_PERF_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_pc(in_pc), .in_tag(in_tag),
        .rs_valid(rs_valid), .rs_ready(rs_ready),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready),
        .out_type(out_type), .out_class(out_class), .out_pc(out_pc), .out_tag(out_tag),
        .illegal(illegal)
`ifdef ISSUE_CLASSIFY_PERF_EN
        , .perf_calc(perf_calc), .perf_mem(perf_mem)
        , .perf_ctrl(perf_ctrl), .perf_illegal(perf_illegal)
`endif
    );

    // Class from the instruction-set membership lists.
    function automatic logic [2:0] ref_class(input logic [5:0] ty);
        int unsigned t;
        t = 32'(ty);
        if (t inside {INST_LUI, INST_AUIPC, INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
                      INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND, INST_ADDI, INST_SLTI,
                      INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI, INST_SLLI, INST_SRLI, INST_SRAI})
            return 3'd0;
        if (t inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU}) return 3'd1;
        if (t inside {INST_SB, INST_SH, INST_SW}) return 3'd2;
        if (t inside {INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU}) return 3'd3;
        if (t inside {INST_JAL, INST_JALR}) return 3'd4;
        return 3'd7;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {in_ready, rs_valid, lsb_valid, illegal, out_type, out_class, out_pc, out_tag};
    endfunction

    function automatic logic [VW-1:0] expect_vec();
        logic [2:0] c;
        logic rv, lv, il;
        if (mq.size() == 0) return {1'b1, {(VW-1){1'b0}}};
        c  = ref_class(mq[0].ty);
        rv = c inside {3'd0, 3'd3, 3'd4};
        lv = c inside {3'd1, 3'd2};
        il = (c == 3'd7) && !flush && !rst;
        return {mq.size() < DEPTH, rv, lv, il, mq[0].ty, c, mq[0].pc, mq[0].tag};
    endfunction

    task automatic drive(input logic r, input logic fl, input logic iv, input logic [5:0] ty,
                         input logic [31:0] pc, input logic [3:0] tag, input logic rr, input logic lr);
        @(negedge clk);
        rst = r; flush = fl; in_valid = iv; in_type = ty; in_pc = pc; in_tag = tag;
        rs_ready = rr; lsb_ready = lr;
        #1;
    endtask

    // Apply the clock edge to the model: reset/flush empty it, else pop head then push.
    task automatic advance();
        logic do_push, do_pop;
        logic [2:0] c;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = 1'b0;
        if (mq.size() > 0) begin
            c = ref_class(mq[0].ty);
            do_pop = (c == 3'd7) || ((c inside {3'd0, 3'd3, 3'd4}) && rs_ready)
                     || ((c inside {3'd1, 3'd2}) && lsb_ready);
        end
        @(posedge clk);
        if (rst || flush) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{ty: in_type, pc: in_pc, tag: in_tag});
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, T_ADD, 32'h10, 4'd1, 1'b0, 1'b0); advance();
        drive(1'b1, 1'b0, 1'b1, T_BAD, 32'h14, 4'd2, 1'b0, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== {1'b1, {(VW-1){1'b0}}}) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {1'b1, {(VW-1){1'b0}}});
        end
        advance();
    endtask

    task automatic test_single_calc();
        logic [VW-1:0] exp;
        drive(1'b0, 1'b0, 1'b1, T_ADD, 32'h100, 4'd3, 1'b1, 1'b0);
        exp = expect_vec(); checks++;
        if (obs_vec() !== exp) begin failures++; $display("FAIL calc_push: got %h expected %h", obs_vec(), exp); end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if ({rs_valid, lsb_valid, out_tag, out_class, out_pc} !== {1'b1, 1'b0, 4'd3, 3'd0, 32'h100}) begin
            failures++;
            $display("FAIL calc_head: got rs=%b lsb=%b tag=%0d cls=%0d pc=%h expected rs=1 lsb=0 tag=3 cls=0 pc=100",
                     rs_valid, lsb_valid, out_tag, out_class, out_pc);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== {1'b1, {(VW-1){1'b0}}}) begin
            failures++; $display("FAIL calc_drained: got %h expected empty", obs_vec());
        end
        advance();
    endtask

    task automatic test_in_order_block();
        logic [VW-1:0] exp;
        drive(1'b0, 1'b0, 1'b1, T_LW,   32'h200, 4'd5, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b1, T_ADDI, 32'h204, 4'd6, 1'b1, 1'b0); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
            checks++;
            if ({lsb_valid, rs_valid, out_tag} !== {1'b1, 1'b0, 4'd5}) begin
                failures++;
                $display("FAIL order_block: got lsb=%b rs=%b tag=%0d expected lsb=1 rs=0 tag=5",
                         lsb_valid, rs_valid, out_tag);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
            exp = expect_vec(); checks++;
            if (obs_vec() !== exp) begin failures++; $display("FAIL order_release: got %h expected %h", obs_vec(), exp); end
            advance();
        end
    endtask

    task automatic test_full_wrap();
        logic [VW-1:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, T_ADD, 32'h300 + 32'(i * 4), 4'(8 + i), 1'b0, 1'b0);
            exp = expect_vec(); checks++;
            if (obs_vec() !== exp) begin failures++; $display("FAIL full_fill: got %h expected %h", obs_vec(), exp); end
            advance();
        end
        drive(1'b0, 1'b0, 1'b1, T_ADD, 32'h3ff, 4'd15, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
            checks++;
            if ({rs_valid, out_tag} !== {1'b1, 4'(8 + i)}) begin
                failures++; $display("FAIL full_order: got rs=%b tag=%0d expected rs=1 tag=%0d", rs_valid, out_tag, 8 + i);
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, i < 2, T_ADDI, 32'h400 + 32'(i), 4'(i), 1'b1, 1'b0);
            exp = expect_vec(); checks++;
            if (obs_vec() !== exp) begin failures++; $display("FAIL wrap_reuse: got %h expected %h", obs_vec(), exp); end
            advance();
        end
    endtask

    task automatic test_illegal();
        drive(1'b0, 1'b0, 1'b1, T_BAD, 32'h500, 4'd1, 1'b0, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b1, T_BEQ, 32'h504, 4'd2, 1'b0, 1'b0);
        checks++;
        if ({illegal, rs_valid, lsb_valid} !== 3'b100) begin
            failures++; $display("FAIL illegal_pulse: got ill/rs/lsb=%b expected 100", {illegal, rs_valid, lsb_valid});
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if ({illegal, rs_valid, out_class, out_tag} !== {1'b0, 1'b1, 3'd3, 4'd2}) begin
            failures++;
            $display("FAIL illegal_then_beq: got ill=%b rs=%b cls=%0d tag=%0d expected ill=0 rs=1 cls=3 tag=2",
                     illegal, rs_valid, out_class, out_tag);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0); advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, T_ADD, 32'h600, 4'(i), 1'b0, 1'b0); advance();
        end
        drive(1'b0, 1'b1, 1'b1, T_ADD, 32'h60c, 4'd9, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== {1'b1, {(VW-1){1'b0}}}) begin
            failures++; $display("FAIL flush_clear: got %h expected empty", obs_vec());
        end
        advance();
    endtask

    task automatic test_random();
        logic [VW-1:0] exp;
        for (int i = 0; i < 600; i++) begin
            drive(1'b0, $urandom_range(0, 24) == 0, 1'($urandom), 6'($urandom_range(0, 63)),
                  $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
            exp = expect_vec(); checks++;
            if (obs_vec() !== exp) begin
                failures++; $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp);
            end
            advance();
        end
    endtask

`ifdef ISSUE_CLASSIFY_PERF_EN
    task automatic test_perf();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0); advance();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, i < 5, T_SW, 32'h700, 4'(i), 1'b0, 1'b1); advance();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (perf_mem !== 2'd3) begin failures++; $display("FAIL perf_sat: got %0d expected 3", perf_mem); end
        advance();
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (perf_mem !== 2'd3) begin failures++; $display("FAIL perf_flush: got %0d expected 3", perf_mem); end
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0); advance();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (perf_mem !== 2'd0) begin failures++; $display("FAIL perf_reset: got %0d expected 0", perf_mem); end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_single_calc();
        test_in_order_block();
        test_full_wrap();
        test_illegal();
        test_flush();
        test_random();
`ifdef ISSUE_CLASSIFY_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
